pipe_stage_buf: RTL

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_buf.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe stage buffer: occupancy encoding and default widths.
// The optional statistics counters are enabled with the macro PIPE_STAGE_STATS_EN.
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) pipeline stage with freeze and flush.
// Define PIPE_STAGE_STATS_EN to add the stat_stall / stat_flush counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        dbg_state
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_stall,
  output logic [CNT_W-1:0]  stat_flush
`endif
);

  // Handshake: a beat moves on a side when its valid and ready are both 1 in
  // the same cycle; valid never depends on ready, and in_ready does not
  // depend on out_ready (it is registered, only masked by freeze).

  occ_e              r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, r_skid, w_main_nxt, w_skid_nxt;
  logic              r_rdy, w_rdy_nxt;
  logic              w_in_xfer, w_out_xfer;

  assign in_ready   = r_rdy & ~freeze;
  assign out_valid  = (r_state != EMPTY) & ~freeze;
  assign out_data   = r_main;
  assign dbg_state  = r_state;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  // Freeze needs no branch here: it forces both transfers low, so everything holds.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_data;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = in_data;
          end else if (w_in_xfer) begin
            w_state_nxt = TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = '0;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
    w_rdy_nxt = (w_state_nxt != TWO);
  end

`ifdef PIPE_STAGE_STATS_EN
  logic w_stall_evt, w_flush_evt;

  assign w_stall_evt = out_valid & ~out_ready;
  assign w_flush_evt = flush & (r_state != EMPTY);

  sat_counter #(.W(CNT_W)) u_stat_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall_evt),
    .o_count (stat_stall)
  );

  sat_counter #(.W(CNT_W)) u_stat_flush (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_flush_evt),
    .o_count (stat_flush)
  );
`endif

endmodule
